// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and result bundle between a requester and the binary-to-BCD converter.
// The master drives the value and start request; the slave returns status and digits.
interface bin_to_bcd_seq_if #(
    parameter int IN_WIDTH = 14
);
    logic [IN_WIDTH-1:0] bin;
    logic                start;
    logic                busy;
    logic                done;
    logic                ovf;
    logic [3:0]          num3;
    logic [3:0]          num2;
    logic [3:0]          num1;
    logic [3:0]          num0;

    modport master (
        output bin, start,
        input  busy, done, ovf, num3, num2, num1, num0
    );

    modport slave (
        input  bin, start,
        output busy, done, ovf, num3, num2, num1, num0
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one input bit per clock, four BCD digits out.
// Result registers only change on the finishing edge, so a downstream display never sees partial digits.
module bin_to_bcd_seq #(
    parameter int IN_WIDTH = 14,
    parameter int MAX_VAL  = 9999
) (
    input  logic              clk,
    input  logic              rst_n,
    bin_to_bcd_seq_if.slave   bus
);
    localparam int          CNT_W = $clog2(IN_WIDTH + 1);
    localparam logic [31:0] MAX_U = MAX_VAL;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_FINISH
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IN_WIDTH-1:0] r_bin;
    logic [15:0]         r_bcd;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_sat;
    logic [15:0]         r_num;
    logic                r_ovf;
    logic                r_done;
    logic                r_busy;
    logic [15:0]         w_adj;
    logic                w_sat;

    // Add 3 to every nibble that is 5 or more, so the next shift carries correctly into the next decade.
    function automatic logic [15:0] add3(input logic [15:0] v);
        logic [15:0] r;
        logic [3:0]  n;
        r = v;
        for (int i = 0; i < 4; i++) begin
            n = v[4*i +: 4];
            r[4*i +: 4] = (n >= 4'd5) ? n + 4'd3 : n;
        end
        return r;
    endfunction

    assign w_adj = add3(r_bcd);
    assign w_sat = ({{(32 - IN_WIDTH){1'b0}}, bus.bin} > MAX_U);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (bus.start) w_state_nxt = S_SHIFT;
            S_SHIFT:  if (r_cnt == CNT_W'(1)) w_state_nxt = S_FINISH;
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_sat  <= 1'b0;
            r_num  <= '0;
            r_ovf  <= 1'b0;
            r_done <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_bin  <= bus.bin;
                        r_bcd  <= '0;
                        r_cnt  <= CNT_W'(IN_WIDTH);
                        r_sat  <= w_sat;
                        r_busy <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    r_bcd <= {w_adj[14:0], r_bin[IN_WIDTH-1]};
                    r_bin <= {r_bin[IN_WIDTH-2:0], 1'b0};
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                S_FINISH: begin
                    r_num  <= r_sat ? 16'h9999 : r_bcd;
                    r_ovf  <= r_sat;
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: r_busy <= 1'b0;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.ovf  = r_ovf;
    assign bus.num3 = r_num[15:12];
    assign bus.num2 = r_num[11:8];
    assign bus.num1 = r_num[7:4];
    assign bus.num0 = r_num[3:0];
endmodule
